// File: rtl/n64_region_decoder.sv
// n64_region_decoder
// Two-stage PI address decoder: a runtime-programmable table of inclusive
// address windows maps each lookup to a bank, prefetch/SRAM flags and a
// translated SDRAM address. The highest-index region that hits wins.
module n64_region_decoder #(
  parameter int REGIONS      = 8,
  parameter int OUT_WIDTH    = 26,
  parameter int BANK_WIDTH   = 4,
  parameter int INVALID_BANK = 0,
  localparam int IDX_W       = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  // configuration port
  input  logic                       i_cfg_write,
  input  logic [$clog2(REGIONS)+1:0] i_cfg_addr,
  input  logic [31:0]                i_cfg_wdata,
  output logic [31:0]                o_cfg_rdata,
  // lookup request stream
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_address,
  // lookup result stream
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [OUT_WIDTH-1:0]       o_translated_address,
  output logic [BANK_WIDTH-1:0]      o_bank,
  output logic                       o_bank_prefetch,
  output logic                       o_sram_request,
  output logic [IDX_W-1:0]           o_hit_index,
  output logic [15:0]                o_miss_count
);

  localparam logic [BANK_WIDTH-1:0] MISS_BANK = BANK_WIDTH'(INVALID_BANK);

  localparam logic [1:0] FIELD_BASE   = 2'd0;
  localparam logic [1:0] FIELD_END    = 2'd1;
  localparam logic [1:0] FIELD_OFFSET = 2'd2;
  localparam logic [1:0] FIELD_ATTR   = 2'd3;

  // ---------------------------------------------------------------------------
  // Configuration address decode
  // ---------------------------------------------------------------------------
  logic [4:0]       w_cfg_region;
  logic [1:0]       w_cfg_field;
  logic             w_cfg_in_range;
  logic [IDX_W-1:0] w_cfg_idx;

  assign w_cfg_region   = 5'(i_cfg_addr >> 2);
  assign w_cfg_field    = i_cfg_addr[1:0];
  assign w_cfg_in_range = ({27'd0, w_cfg_region} < 32'(REGIONS));
  assign w_cfg_idx      = IDX_W'(w_cfg_region);

  // ---------------------------------------------------------------------------
  // Region table: one register set per region, exported as flat arrays
  // ---------------------------------------------------------------------------
  logic [31:0]           w_base   [REGIONS];
  logic [31:0]           w_end    [REGIONS];
  logic [OUT_WIDTH-1:0]  w_offset [REGIONS];
  logic [31:0]           w_attr   [REGIONS];
  logic                  w_en     [REGIONS];
  logic                  w_pf     [REGIONS];
  logic                  w_sram   [REGIONS];
  logic                  w_rebase [REGIONS];
  logic [BANK_WIDTH-1:0] w_bank   [REGIONS];
  logic [REGIONS-1:0]    w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < REGIONS; gi++) begin : gen_region
      logic [31:0]           r_base;
      logic [31:0]           r_end;
      logic [OUT_WIDTH-1:0]  r_offset;
      logic                  r_en;
      logic                  r_pf;
      logic                  r_sram;
      logic                  r_rebase;
      logic [BANK_WIDTH-1:0] r_bank;
      logic                  w_sel;

      assign w_sel = i_cfg_write && w_cfg_in_range && (w_cfg_region == 5'(gi));

      // Field write for this region; reset leaves the region disabled
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_base   <= '0;
          r_end    <= '0;
          r_offset <= '0;
          r_en     <= 1'b0;
          r_pf     <= 1'b0;
          r_sram   <= 1'b0;
          r_rebase <= 1'b0;
          r_bank   <= '0;
        end else if (w_sel) begin
          case (w_cfg_field)
            FIELD_BASE:   r_base   <= i_cfg_wdata;
            FIELD_END:    r_end    <= i_cfg_wdata;
            FIELD_OFFSET: r_offset <= i_cfg_wdata[OUT_WIDTH-1:0];
            default: begin
              r_en     <= i_cfg_wdata[0];
              r_pf     <= i_cfg_wdata[1];
              r_sram   <= i_cfg_wdata[2];
              r_rebase <= i_cfg_wdata[3];
              r_bank   <= i_cfg_wdata[8 +: BANK_WIDTH];
            end
          endcase
        end
      end

      assign w_base[gi]   = r_base;
      assign w_end[gi]    = r_end;
      assign w_offset[gi] = r_offset;
      assign w_en[gi]     = r_en;
      assign w_pf[gi]     = r_pf;
      assign w_sram[gi]   = r_sram;
      assign w_rebase[gi] = r_rebase;
      assign w_bank[gi]   = r_bank;
      assign w_attr[gi]   = 32'({r_bank, 4'b0000, r_rebase, r_sram, r_pf, r_en});

      // Unsigned inclusive window; end < base can never satisfy both compares
      assign w_hit[gi] = r_en && (i_address >= r_base) && (i_address <= r_end);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Configuration read-back (registered; same-cycle write returns old value)
  // ---------------------------------------------------------------------------
  logic [31:0] w_rd_data;
  logic [31:0] r_cfg_rdata;

  // Select the addressed field; out-of-range regions read as zero
  always_comb begin
    w_rd_data = '0;
    if (w_cfg_in_range) begin
      case (w_cfg_field)
        FIELD_BASE:   w_rd_data = w_base[w_cfg_idx];
        FIELD_END:    w_rd_data = w_end[w_cfg_idx];
        FIELD_OFFSET: w_rd_data = 32'(w_offset[w_cfg_idx]);
        default:      w_rd_data = w_attr[w_cfg_idx];
      endcase
    end
  end

  // Register the read-back every cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) r_cfg_rdata <= '0;
    else         r_cfg_rdata <= w_rd_data;
  end

  assign o_cfg_rdata = r_cfg_rdata;

  // ---------------------------------------------------------------------------
  // Priority select: later (higher-index) hits override earlier ones
  // ---------------------------------------------------------------------------
  logic                  w_win_hit;
  logic [IDX_W-1:0]      w_win_idx;
  logic [OUT_WIDTH-1:0]  w_win_base;
  logic [OUT_WIDTH-1:0]  w_win_offset;
  logic                  w_win_pf;
  logic                  w_win_sram;
  logic                  w_win_rebase;
  logic [BANK_WIDTH-1:0] w_win_bank;

  // Walk regions in ascending order so the last hit seen is the winner
  always_comb begin
    w_win_hit    = 1'b0;
    w_win_idx    = '0;
    w_win_base   = '0;
    w_win_offset = '0;
    w_win_pf     = 1'b0;
    w_win_sram   = 1'b0;
    w_win_rebase = 1'b0;
    w_win_bank   = MISS_BANK;
    for (int r = 0; r < REGIONS; r++) begin
      if (w_hit[r]) begin
        w_win_hit    = 1'b1;
        w_win_idx    = IDX_W'(r);
        w_win_base   = w_base[r][OUT_WIDTH-1:0];
        w_win_offset = w_offset[r];
        w_win_pf     = w_pf[r];
        w_win_sram   = w_sram[r];
        w_win_rebase = w_rebase[r];
        w_win_bank   = w_bank[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_stall;
  logic w_ready;
  logic w_accept;
  logic w_s1_load;
  logic w_s2_en;

  assign w_stall   = r_out_valid && !i_ready;
  assign w_ready   = !i_cfg_write && !(r_s1_valid && w_stall);
  assign w_accept  = i_valid && w_ready;
  // Stage 1 may refill while stage 2 is stalled, as long as it is empty
  assign w_s1_load = !(r_s1_valid && w_stall);
  assign w_s2_en   = !w_stall;
  assign o_ready   = w_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: capture address and the winning region's parameters, so later
  // configuration writes cannot disturb this lookup
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0]  r_s1_addr;
  logic                  r_s1_hit;
  logic [IDX_W-1:0]      r_s1_idx;
  logic [OUT_WIDTH-1:0]  r_s1_base;
  logic [OUT_WIDTH-1:0]  r_s1_offset;
  logic                  r_s1_pf;
  logic                  r_s1_sram;
  logic                  r_s1_rebase;
  logic [BANK_WIDTH-1:0] r_s1_bank;

  // Stage 1 register with hold during a full-pipe stall
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_hit    <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_base   <= '0;
      r_s1_offset <= '0;
      r_s1_pf     <= 1'b0;
      r_s1_sram   <= 1'b0;
      r_s1_rebase <= 1'b0;
      r_s1_bank   <= MISS_BANK;
    end else if (w_s1_load) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr   <= i_address[OUT_WIDTH-1:0];
        r_s1_hit    <= w_win_hit;
        r_s1_idx    <= w_win_idx;
        r_s1_base   <= w_win_base;
        r_s1_offset <= w_win_offset;
        r_s1_pf     <= w_win_pf;
        r_s1_sram   <= w_win_sram;
        r_s1_rebase <= w_win_rebase;
        r_s1_bank   <= w_win_bank;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: translation (all arithmetic wraps at OUT_WIDTH bits)
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] w_rel;
  logic [OUT_WIDTH-1:0] w_trans;

  assign w_rel   = r_s1_rebase ? (r_s1_addr - r_s1_base) : r_s1_addr;
  assign w_trans = r_s1_hit ? (w_rel + r_s1_offset) : r_s1_addr;

  logic [OUT_WIDTH-1:0]  r_out_trans;
  logic [BANK_WIDTH-1:0] r_out_bank;
  logic                  r_out_pf;
  logic                  r_out_sram;
  logic [IDX_W-1:0]      r_out_idx;
  logic                  r_out_miss;

  // Output register; holds all fields while the consumer stalls
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_trans <= '0;
      r_out_bank  <= MISS_BANK;
      r_out_pf    <= 1'b0;
      r_out_sram  <= 1'b0;
      r_out_idx   <= '0;
      r_out_miss  <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_trans <= w_trans;
        r_out_bank  <= r_s1_hit ? r_s1_bank : MISS_BANK;
        r_out_pf    <= r_s1_hit && r_s1_pf;
        r_out_sram  <= r_s1_hit && r_s1_sram;
        r_out_idx   <= r_s1_hit ? r_s1_idx : '0;
        r_out_miss  <= !r_s1_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Miss counter: counts missed results as they are handed downstream
  // ---------------------------------------------------------------------------
  logic [15:0] r_miss_count;

  // Saturating increment on a miss handshake
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_miss_count <= '0;
    end else if (r_out_valid && i_ready && r_out_miss && (r_miss_count != 16'hFFFF)) begin
      r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign o_valid              = r_out_valid;
  assign o_translated_address = r_out_trans;
  assign o_bank               = r_out_bank;
  assign o_bank_prefetch      = r_out_pf;
  assign o_sram_request       = r_out_sram;
  assign o_hit_index          = r_out_idx;
  assign o_miss_count         = r_miss_count;

endmodule

// File: tb/tb_n64_region_decoder.sv
// Self-checking bench for n64_region_decoder: table-driven single lookups
// plus hand-written backpressure, config-during-traffic, reset-flush and
// miss-counter saturation sequences.
module tb_n64_region_decoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset = 1'b0;
  logic        i_cfg_write = 1'b0;
  logic [4:0]  i_cfg_addr = '0;
  logic [31:0] i_cfg_wdata = '0;
  logic [31:0] o_cfg_rdata;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_address = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [25:0] o_translated_address;
  logic [3:0]  o_bank;
  logic        o_bank_prefetch;
  logic        o_sram_request;
  logic [2:0]  o_hit_index;
  logic [15:0] o_miss_count;

  n64_region_decoder #(
    .REGIONS(8), .OUT_WIDTH(26), .BANK_WIDTH(4), .INVALID_BANK(0)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_cfg_write(i_cfg_write), .i_cfg_addr(i_cfg_addr),
    .i_cfg_wdata(i_cfg_wdata), .o_cfg_rdata(o_cfg_rdata),
    .i_valid(i_valid), .o_ready(o_ready), .i_address(i_address),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_translated_address(o_translated_address), .o_bank(o_bank),
    .o_bank_prefetch(o_bank_prefetch), .o_sram_request(o_sram_request),
    .o_hit_index(o_hit_index), .o_miss_count(o_miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  bank;
    logic        pf;
    logic        sram;
    logic [25:0] trans;
    logic [2:0]  idx;
    logic        miss;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int exp_miss = 0;
  vec_t tbl[12];
  vec_t stream_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [1:0] f, input logic [31:0] d);
    i_cfg_write = 1'b1;
    i_cfg_addr  = {idx, f};
    i_cfg_wdata = d;
    tick();
    i_cfg_write = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] idx, input logic [1:0] f, input logic [31:0] exp, input string name);
    i_cfg_addr = {idx, f};
    tick();
    check(name, o_cfg_rdata, exp);
    $display("cfg read r%0d f%0d = 0x%08h", idx, f, o_cfg_rdata);
  endtask

  task automatic program_region(input logic [2:0] idx, input logic [31:0] b, input logic [31:0] e,
                                input logic [31:0] off, input logic [31:0] attr);
    cfg_write(idx, 2'd0, b);
    cfg_write(idx, 2'd1, e);
    cfg_write(idx, 2'd2, off);
    cfg_write(idx, 2'd3, attr);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " o_valid"}, o_valid, 0);
    check({name, " o_ready"}, o_ready, 1);
    check({name, " o_bank"}, o_bank, 0);
    check({name, " o_translated"}, o_translated_address, 0);
    check({name, " o_prefetch"}, o_bank_prefetch, 0);
    check({name, " o_sram"}, o_sram_request, 0);
    check({name, " o_hit_index"}, o_hit_index, 0);
    check({name, " o_miss_count"}, o_miss_count, 0);
    check({name, " o_cfg_rdata"}, o_cfg_rdata, 0);
  endtask

  // Single lookup with i_ready high; checks latency, fields and miss count
  task automatic lookup(input vec_t v, input string name);
    int lat;
    i_valid   = 1'b1;
    i_address = v.addr;
    #1;
    check({name, " ready"}, o_ready, 1);
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, 2);
    check({name, " bank"}, o_bank, v.bank);
    check({name, " prefetch"}, o_bank_prefetch, v.pf);
    check({name, " sram"}, o_sram_request, v.sram);
    check({name, " translated"}, o_translated_address, v.trans);
    check({name, " hit_index"}, o_hit_index, v.idx);
    $display("lookup %s addr=0x%08h bank=%0d pf=%0b sram=%0b idx=%0d trans=0x%07h",
             name, v.addr, o_bank, o_bank_prefetch, o_sram_request, o_hit_index, o_translated_address);
    if (v.miss) exp_miss++;
    tick();
    check({name, " miss_count"}, o_miss_count, exp_miss);
  endtask

  // Stream stream_q through the pipe with an optional i_ready-low window and
  // an optional config write at a given cycle; results checked in order
  task automatic run_stream(input string name, input int lo_start, input int lo_len,
                            input int cfg_cycle, input logic [4:0] cfg_a, input logic [31:0] cfg_d);
    int n;
    int sent;
    int got;
    bit stall_prev;
    bit saw_ready_low;
    logic [25:0] snap_t;
    logic [3:0]  snap_b;
    logic [2:0]  snap_i;
    n = stream_q.size();
    sent = 0;
    got = 0;
    stall_prev = 0;
    saw_ready_low = 0;
    snap_t = '0;
    snap_b = '0;
    snap_i = '0;
    for (int k = 0; k < 40 && got < n; k++) begin
      i_ready     = !(k >= lo_start && k < lo_start + lo_len);
      i_cfg_write = (k == cfg_cycle);
      i_cfg_addr  = cfg_a;
      i_cfg_wdata = cfg_d;
      i_valid     = (sent < n);
      i_address   = (sent < n) ? stream_q[sent].addr : 32'd0;
      #1;
      if (k == cfg_cycle) check({name, " ready during cfg write"}, o_ready, 0);
      if (stall_prev) begin
        check({name, " hold valid"}, o_valid, 1);
        check({name, " hold translated"}, o_translated_address, snap_t);
        check({name, " hold bank"}, o_bank, snap_b);
        check({name, " hold hit_index"}, o_hit_index, snap_i);
      end
      if (!i_ready && o_valid && i_valid && !o_ready) saw_ready_low = 1;
      if (o_valid && i_ready) begin
        check({name, " bank"}, o_bank, stream_q[got].bank);
        check({name, " translated"}, o_translated_address, stream_q[got].trans);
        check({name, " hit_index"}, o_hit_index, stream_q[got].idx);
        check({name, " sram"}, o_sram_request, stream_q[got].sram);
        check({name, " prefetch"}, o_bank_prefetch, stream_q[got].pf);
        $display("stream %s result %0d addr=0x%08h bank=%0d idx=%0d trans=0x%07h",
                 name, got, stream_q[got].addr, o_bank, o_hit_index, o_translated_address);
        if (stream_q[got].miss) exp_miss++;
        got++;
      end
      stall_prev = o_valid && !i_ready;
      if (stall_prev) begin
        snap_t = o_translated_address;
        snap_b = o_bank;
        snap_i = o_hit_index;
      end
      if (i_valid && o_ready) sent++;
      tick();
    end
    i_valid     = 1'b0;
    i_cfg_write = 1'b0;
    i_ready     = 1'b1;
    #1;
    check({name, " result count"}, got, n);
    if (lo_len > 0) check({name, " ready dropped"}, saw_ready_low, 1);
    check({name, " no duplicate"}, o_valid, 0);
    check({name, " miss_count"}, o_miss_count, exp_miss);
  endtask

  initial begin
    int seen;
    vec_t v0;

    // Expected results once every region below is programmed
    tbl[0]  = '{32'h1000_0020, 4'd2, 1'b0, 1'b0, 26'h000_0010, 3'd5, 1'b0}; // r5 rebase, wrap
    tbl[1]  = '{32'h1000_1000, 4'd1, 1'b1, 1'b0, 26'h000_1000, 3'd0, 1'b0}; // past r5 -> r0
    tbl[2]  = '{32'h13FF_FFFF, 4'd1, 1'b1, 1'b0, 26'h3FF_FFFF, 3'd0, 1'b0}; // r0 end
    tbl[3]  = '{32'h1400_0000, 4'd0, 1'b0, 1'b0, 26'h000_0000, 3'd0, 1'b1}; // r0 end+1
    tbl[4]  = '{32'h0FFF_FFFF, 4'd0, 1'b0, 1'b0, 26'h3FF_FFFF, 3'd0, 1'b1}; // r0 base-1
    tbl[5]  = '{32'h1000_0810, 4'd4, 1'b0, 1'b0, 26'h000_0010, 3'd7, 1'b0}; // r7 over r5/r0
    tbl[6]  = '{32'h8000_1234, 4'd7, 1'b0, 1'b1, 26'h000_1334, 3'd3, 1'b0}; // sram + offset
    tbl[7]  = '{32'h2000_0000, 4'd0, 1'b0, 1'b0, 26'h000_0000, 3'd0, 1'b1}; // end<base region
    tbl[8]  = '{32'h1FFF_FFFF, 4'd0, 1'b0, 1'b0, 26'h3FF_FFFF, 3'd0, 1'b1}; // end<base region
    tbl[9]  = '{32'h3000_0010, 4'd0, 1'b0, 1'b0, 26'h000_0010, 3'd0, 1'b1}; // disabled region
    tbl[10] = '{32'h1000_0004, 4'd2, 1'b0, 1'b0, 26'h3FF_FFF4, 3'd5, 1'b0}; // r5 wins over r0
    tbl[11] = '{32'h1000_0FFF, 4'd2, 1'b0, 1'b0, 26'h000_0FEF, 3'd5, 1'b0}; // r5 end

    // Reset values
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Decode with only r0 programmed
    program_region(3'd0, 32'h1000_0000, 32'h13FF_FFFF, 32'h0, 32'h0000_0103);
    v0 = '{32'h1000_0004, 4'd1, 1'b1, 1'b0, 26'h000_0004, 3'd0, 1'b0};
    lookup(v0, "r0_only");

    // Field masking on read-back, and same-cycle write/read returns old value
    cfg_write(3'd1, 2'd2, 32'hFFFF_FFFF);
    cfg_read(3'd1, 2'd2, 32'h03FF_FFFF, "offset mask");
    cfg_write(3'd1, 2'd3, 32'hFFFF_FFFF);
    cfg_read(3'd1, 2'd3, 32'h0000_0F0F, "attr mask");
    cfg_write(3'd1, 2'd3, 32'h0);
    cfg_read(3'd0, 2'd3, 32'h0000_0103, "r0 attr");
    i_cfg_addr = {3'd4, 2'd0};
    cfg_write(3'd4, 2'd0, 32'h1234_5678);
    check("write-read same cycle old", o_cfg_rdata, 32'h0);
    tick();
    check("write-read next cycle new", o_cfg_rdata, 32'h1234_5678);
    cfg_write(3'd4, 2'd0, 32'h0);

    // Remaining regions
    program_region(3'd5, 32'h1000_0000, 32'h1000_0FFF, 32'h03FF_FFF0, 32'h0000_0209);
    program_region(3'd7, 32'h1000_0800, 32'h1000_08FF, 32'h0,         32'h0000_0409);
    program_region(3'd3, 32'h8000_0000, 32'h8000_FFFF, 32'h0000_0100, 32'h0000_0705);
    program_region(3'd2, 32'h2000_0000, 32'h1FFF_FFFF, 32'h0,         32'h0000_0301);
    program_region(3'd6, 32'h3000_0000, 32'h3000_FFFF, 32'h0,         32'h0000_0900);

    for (int i = 0; i < 12; i++) begin
      lookup(tbl[i], $sformatf("tbl%0d", i));
    end

    // Backpressure: 4 lookups, i_ready low for cycles 2..4
    stream_q = {};
    stream_q.push_back(tbl[10]);
    stream_q.push_back(tbl[0]);
    stream_q.push_back(tbl[6]);
    stream_q.push_back(tbl[5]);
    run_stream("backpressure", 2, 3, -1, 5'd0, 32'd0);

    // Config during traffic: disable r0 the cycle after A is accepted
    stream_q = {};
    stream_q.push_back(tbl[1]);
    stream_q.push_back('{32'h1000_1004, 4'd0, 1'b0, 1'b0, 26'h000_1004, 3'd0, 1'b1});
    run_stream("cfg_traffic", 0, 0, 1, {3'd0, 2'd3}, 32'h0);

    // Reset with two lookups in flight
    i_valid   = 1'b1;
    i_address = 32'h1000_0020;
    tick();
    i_address = 32'h1000_0810;
    i_reset   = 1'b1;
    tick();
    i_reset = 1'b0;
    i_valid = 1'b0;
    #1;
    check_reset_outputs("reset flush");
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_valid) seen++;
    end
    check("reset flush no o_valid", seen, 0);
    $display("reset flush: o_valid seen %0d times", seen);
    exp_miss = 0;
    for (int r = 0; r < 8; r++) begin
      for (int f = 0; f < 4; f++) begin
        cfg_read(3'(r), 2'(f), 32'h0, $sformatf("cleared r%0d f%0d", r, f));
      end
    end

    // Saturation: every region disabled, so every lookup misses
    i_valid   = 1'b1;
    i_address = 32'h1000_0000;
    for (int k = 0; k < 65540; k++) begin
      tick();
    end
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    check("miss_count saturation", o_miss_count, 32'h0000_FFFF);
    $display("saturation: 65540 misses, o_miss_count=0x%04h", o_miss_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/n64_region_decoder.md
# n64_region_decoder

Parametrised, pipelined successor to the fixed-map N64 bank decoder. Maps each 32-bit PI bus address to a target bank, prefetch flag, SRAM-request flag and translated SDRAM address. The map is a runtime-programmable table of REGIONS inclusive address windows. It sits between the N64 PI front-end and the bank arbiter, with a valid/ready lookup stream and a CPU-side configuration port.

## Interface
- REGIONS, 8: number of programmable regions (1..16).
- OUT_WIDTH, 26: translated address width.
- BANK_WIDTH, 4: bank code width.
- INVALID_BANK, 0: bank code emitted on miss.
- i_clk  in  1  clock; one clock domain.
- i_reset  in  1  reset, synchronous, active-high.
- i_cfg_write  in  1  config write strobe.
- i_cfg_addr  in  $clog2(REGIONS)+2  {region index, field[1:0]}.
- i_cfg_wdata  in  32  write data.
- o_cfg_rdata  out  32  read-back of field at i_cfg_addr, registered.
- i_valid  in  1  lookup request valid.
- o_ready  out  1  lookup accepted when i_valid && o_ready.
- i_address  in  32  PI address.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_translated_address  out  OUT_WIDTH  translated address.
- o_bank  out  BANK_WIDTH  target bank.
- o_bank_prefetch  out  1  prefetch allowed.
- o_sram_request  out  1  region flagged as SRAM.
- o_hit_index  out  $clog2(REGIONS)  winning region; 0 on miss.
- o_miss_count  out  16  saturating count of missed lookups.

## Operation
- Region fields: 0 = base[31:0]; 1 = end[31:0] (inclusive); 2 = offset[OUT_WIDTH-1:0], upper bits read as 0; 3 = attr.
- attr bits: bit0 enable, bit1 prefetch, bit2 sram, bit3 rebase, bits[8+BANK_WIDTH-1:8] bank. Unlisted bits read as 0.
- Hit condition for region r: enable && base <= addr <= end, using unsigned 32-bit compares. A region with end < base never hits.
- Priority: when several regions hit, the highest region index wins. Later regions override earlier ones.
- Translation with rebase=0: addr[OUT_WIDTH-1:0] + offset.
- Translation with rebase=1: (addr - base)[OUT_WIDTH-1:0] + offset.
- All translation arithmetic is modulo 2^OUT_WIDTH; carries are discarded.
- Miss: bank = INVALID_BANK, prefetch = 0, sram = 0, hit_index = 0, translated = addr[OUT_WIDTH-1:0]. o_miss_count increments on the result handshake and saturates at 0xFFFF.
- Config write: applies on the write edge. o_ready is forced low in any cycle with i_cfg_write.
- In-flight lookups: a lookup already in stage 1 completes with the attributes, offset and base captured at its stage-1 edge. A write never alters an in-flight result.
- Config read: o_cfg_rdata updates every cycle from i_cfg_addr. A write and a read of the same field in one cycle returns the old value.
- Out-of-range region index (index >= REGIONS): writes are ignored; reads return 0.

## Timing
- Two-stage pipeline; latency is 2 cycles from an accepted request to o_valid.
- Stage 1 edge: registers the address, winning index, hit flag and the winning region's base/offset/attr.
- Stage 2 edge: registers the translated address and output flags.
- Stall: when o_valid && !i_ready, all outputs hold stable and stage 1 holds. o_ready = !i_cfg_write && !(s1_valid && o_valid && !i_ready).
- Throughput is one lookup per cycle with no bubbles while i_ready = 1.
- Reset values, cycle after reset: o_valid = 0, o_ready = 1, o_bank = INVALID_BANK, o_translated_address = 0, o_bank_prefetch = 0, o_sram_request = 0, o_hit_index = 0, o_miss_count = 0, o_cfg_rdata = 0.
- Reset clears all region fields, so every region is disabled.
- Reset mid-operation flushes both stages; no result is emitted for lookups in flight.

## Test plan
- Decode and translation:
  - Stimulus: reset; program r0 = {base 0x1000_0000, end 0x13FF_FFFF, offset 0, attr bank 1, prefetch, enable}; look up 0x1000_0004.
  - Response: 2 cycles later o_valid, bank 1, prefetch 1, translated 0x000_0004, hit_index 0.
- Priority and rebase:
  - Stimulus: add r5 = {base 0x1000_0000, end 0x1000_0FFF, offset 0x3FF_FFF0, rebase, bank 2}; look up 0x1000_0020.
  - Response: hit_index 5, bank 2, translated 0x000_0010 (modulo wrap). Lookup 0x1000_1000 returns r0.
- Boundaries and misses:
  - Stimulus: look up end, end+1, base-1 of r0; program a region with end < base.
  - Response: end hits r0. end+1 and base-1 miss: bank 0, translated = addr[25:0], miss_count steps by 2. The end < base region never hits.
- Backpressure:
  - Stimulus: stream 4 lookups with i_ready low for 3 cycles mid-stream.
  - Response: outputs hold, o_ready drops, no result is lost or duplicated, order is preserved.
- Config during traffic:
  - Stimulus: write r0 attr to disabled in the cycle after lookup A is accepted; lookup B follows.
  - Response: o_ready is low during the write cycle. A returns bank 1; B misses.
- Reset and saturation:
  - Stimulus: assert i_reset with 2 lookups in flight.
  - Response: no o_valid afterward, and read-back of every field = 0.
  - Stimulus: force 65540 misses.
  - Response: o_miss_count = 0xFFFF.
